// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Tuse / result-stage encodings used on the D-stage decode inputs
//   - bit positions of the forward-select outputs, matching the existing
//     forward multiplexer encodings
//   - E and M shadow-stage record layouts
//   - small comparator helpers shared by the stall logic
package hazard_pkg;

    // Tuse value meaning "this operand is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Stage that produces the D instruction's result
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_E    = 2'd1;
    localparam logic [1:0] RES_M    = 2'd2;

    // dForwardSelect bit positions
    localparam int DFWD_RS_M = 1;
    localparam int DFWD_RT_M = 0;

    // eForwardSelect bit positions (A = rs operand, B = rt operand)
    localparam int EFWD_A_W = 3;
    localparam int EFWD_A_M = 2;
    localparam int EFWD_B_W = 1;
    localparam int EFWD_B_M = 0;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       mdStart;
        logic       mdDiv;
    } e_shadow_t;

    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_shadow_t;

    // Cycles until the result exists, counted from E entry.
    function automatic logic [1:0] tnew_of(input logic [1:0] res);
        case (res)
            RES_E:   return 2'd1;
            RES_M:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // A source stalls when an older producer in flight will not have its
    // result ready by the time this source is consumed.
    function automatic logic src_stalls(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (dst == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy sequencer for the multi-cycle multiply/divide unit.
//   clk    in   pipeline clock
//   rst_n  in   asynchronous active-low reset
//   start  in   a mult/div sits in E this cycle; load the counter on the edge
//   isDiv  in   with start: divide (else multiply)
//   busy   out  counter is nonzero
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic isDiv,
    output logic busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] cnt_q, cnt_d;

    // A start always reloads, even if the unit is still busy.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = isDiv ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage pipeline. Shadows the register
// fields of the E, M and W stages, decides stalls, and drives the select
// codes of the existing forward multiplexers.
//   clk, rst_n            clock, asynchronous active-low reset
//   dRs, dRt              D-stage source registers
//   dRsTuse, dRtTuse      cycles until each operand is needed (3 = unused)
//   dDst, dResStage       D-stage write register and producing stage
//   dMdStart, dMdDiv      D instruction starts mult (dMdDiv=0) or div
//   dMdUse                D instruction touches the HI/LO unit
//   stall                 freeze PC and IF/ID, flush ID/EX
//   dForwardSelect        [1] rs from M, [0] rt from M
//   eForwardSelect        [3]/[2] A from W/M, [1]/[0] B from W/M
//   mForwardSelect        store data from W
//   mdBusy                multiply/divide unit busy
module hazard_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] dRs,
    input  logic [4:0] dRt,
    input  logic [1:0] dRsTuse,
    input  logic [1:0] dRtTuse,
    input  logic [4:0] dDst,
    input  logic [1:0] dResStage,
    input  logic       dMdStart,
    input  logic       dMdDiv,
    input  logic       dMdUse,
    output logic       stall,
    output logic [1:0] dForwardSelect,
    output logic [3:0] eForwardSelect,
    output logic       mForwardSelect,
    output logic       mdBusy
);
    import hazard_pkg::*;

    e_shadow_t  e_q, e_d;
    m_shadow_t  m_q, m_d;
    logic [4:0] w_dst_q, w_dst_d;

    logic rs_stall, rt_stall, md_stall;
    logic a_from_m, b_from_m;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy (
        .clk  (clk),
        .rst_n(rst_n),
        .start(e_q.mdStart),
        .isDiv(e_q.mdDiv),
        .busy (mdBusy)
    );

    // Producer in M can be bypassed only once its value exists (tnew==0).
    function automatic logic m_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic [1:0] tnew);
        return (src != 5'd0) && (src == dst) && (tnew == 2'd0);
    endfunction

    function automatic logic w_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    assign rs_stall = src_stalls(dRs, dRsTuse, e_q.dst, e_q.tnew)
                   || src_stalls(dRs, dRsTuse, m_q.dst, m_q.tnew);
    assign rt_stall = src_stalls(dRt, dRtTuse, e_q.dst, e_q.tnew)
                   || src_stalls(dRt, dRtTuse, m_q.dst, m_q.tnew);
    // mdStart still in E counts as busy: the counter only loads on that edge.
    assign md_stall = dMdUse && (mdBusy || e_q.mdStart);
    assign stall    = rs_stall || rt_stall || md_stall;

    assign a_from_m = m_hit(e_q.rs, m_q.dst, m_q.tnew);
    assign b_from_m = m_hit(e_q.rt, m_q.dst, m_q.tnew);

    always_comb begin
        dForwardSelect = 2'b00;
        dForwardSelect[DFWD_RS_M] = m_hit(dRs, m_q.dst, m_q.tnew);
        dForwardSelect[DFWD_RT_M] = m_hit(dRt, m_q.dst, m_q.tnew);

        // M is the younger producer, so it wins over W.
        eForwardSelect = 4'b0000;
        eForwardSelect[EFWD_A_M] = a_from_m;
        eForwardSelect[EFWD_A_W] = !a_from_m && w_hit(e_q.rs, w_dst_q);
        eForwardSelect[EFWD_B_M] = b_from_m;
        eForwardSelect[EFWD_B_W] = !b_from_m && w_hit(e_q.rt, w_dst_q);

        mForwardSelect = w_hit(m_q.rt, w_dst_q);
    end

    always_comb begin
        // A stall injects an all-zero bubble, which also drops mdStart.
        e_d = '0;
        if (!stall) begin
            e_d.rs      = dRs;
            e_d.rt      = dRt;
            e_d.dst     = dDst;
            e_d.tnew    = tnew_of(dResStage);
            e_d.mdStart = dMdStart;
            e_d.mdDiv   = dMdDiv;
        end
        m_d.rt   = e_q.rt;
        m_d.dst  = e_q.dst;
        m_d.tnew = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
        w_dst_d  = m_q.dst;
    end

    // ---- E -> M -> W shadow advance ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= 5'd0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_dst_q <= w_dst_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic       clk;
    logic       rst_n;
    logic [4:0] dRs, dRt, dDst;
    logic [1:0] dRsTuse, dRtTuse, dResStage;
    logic       dMdStart, dMdDiv, dMdUse;
    logic       stall, mForwardSelect, mdBusy;
    logic [1:0] dForwardSelect;
    logic [3:0] eForwardSelect;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dRs           (dRs),
        .dRt           (dRt),
        .dRsTuse       (dRsTuse),
        .dRtTuse       (dRtTuse),
        .dDst          (dDst),
        .dResStage     (dResStage),
        .dMdStart      (dMdStart),
        .dMdDiv        (dMdDiv),
        .dMdUse        (dMdUse),
        .stall         (stall),
        .dForwardSelect(dForwardSelect),
        .eForwardSelect(eForwardSelect),
        .mForwardSelect(mForwardSelect),
        .mdBusy        (mdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] rsT, rtT;
        logic [4:0] dst;
        logic [1:0] res;
        logic       mds, mdd, mdu;
        logic       st;
        logic [1:0] df;
        logic [3:0] ef;
        logic       mf;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] rsT, input logic [1:0] rtT,
                               input logic [4:0] dst, input logic [1:0] res,
                               input logic st, input logic [1:0] df,
                               input logic [3:0] ef, input logic mf);
        vec_t x;
        x.rs = rs; x.rt = rt; x.rsT = rsT; x.rtT = rtT; x.dst = dst; x.res = res;
        x.mds = 1'b0; x.mdd = 1'b0; x.mdu = 1'b0;
        x.st = st; x.df = df; x.ef = ef; x.mf = mf; x.bz = 1'b0;
        return x;
    endfunction

    function automatic vec_t nop();
        return v(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 2'b00, 4'b0000, 1'b0);
    endfunction

    task automatic drive(input vec_t x);
        dRs = x.rs; dRt = x.rt; dRsTuse = x.rsT; dRtTuse = x.rtT;
        dDst = x.dst; dResStage = x.res;
        dMdStart = x.mds; dMdDiv = x.mdd; dMdUse = x.mdu;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t x);
        chk("stall", idx, 32'(stall), 32'(x.st));
        chk("dForwardSelect", idx, 32'(dForwardSelect), 32'(x.df));
        chk("eForwardSelect", idx, 32'(eForwardSelect), 32'(x.ef));
        chk("mForwardSelect", idx, 32'(mForwardSelect), 32'(x.mf));
        chk("mdBusy", idx, 32'(mdBusy), 32'(x.bz));
    endtask

    // mult/div in D, then mfhi in D until it is allowed to proceed
    task automatic md_seq(input logic isdiv, input int idx);
        vec_t x;
        int   n_st, n_bz, want;
        bit   done;
        want = isdiv ? DIV : MULT;
        x = nop(); x.mds = 1'b1; x.mdd = isdiv; x.mdu = 1'b1;
        drive(x);
        @(negedge clk);
        chk("md_start_stall", idx, 32'(stall), 32'd0);
        chk("md_start_busy", idx, 32'(mdBusy), 32'd0);
        @(posedge clk); #1;
        x = nop(); x.dst = 5'd9; x.res = 2'd1; x.mdu = 1'b1;
        drive(x);
        n_st = 0; n_bz = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("md_first_stall", idx, 32'(stall), 32'd1);
                chk("md_first_busy", idx, 32'(mdBusy), 32'd0);
            end
            if (stall) begin
                n_st++;
                if (mdBusy) n_bz++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL md_timeout #%0d: stall still high after 40 cycles", idx);
        end
        chk("md_stall_cycles", idx, 32'(n_st), 32'(want + 1));
        chk("md_busy_cycles", idx, 32'(n_bz), 32'(want));
        chk("md_release_busy", idx, 32'(mdBusy), 32'd0);
        @(posedge clk); #1;
        drive(nop());
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t x;
        // Tuse: 0 branch, 1 E, 2 store data, 3 unused. res: 1 E, 2 M (load)
        // lw $1 ; addu $2,$1,$1 : one stall, then both operands from W
        tbl.push_back(v(0, 0, 1, 3, 1, 2, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(1, 1, 1, 1, 2, 1, 1, 2'b00, 4'b0000, 0));
        tbl.push_back(v(1, 1, 1, 1, 2, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b1010, 0));
        tbl.push_back(nop());
        tbl.push_back(nop());
        // addu $3 ; beq $3,$0 : one stall, then rs from M in D
        tbl.push_back(v(0, 0, 1, 1, 3, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b1000, 0));
        tbl.push_back(nop());
        tbl.push_back(nop());
        // lw $4 ; beq $4,$4 : two stalls
        tbl.push_back(v(0, 0, 1, 3, 4, 2, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(4, 4, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0));
        tbl.push_back(v(4, 4, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0));
        tbl.push_back(v(4, 4, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(nop());
        tbl.push_back(nop());
        // lw $5 ; sw $5 : no stall, store data from W in M
        tbl.push_back(v(0, 0, 1, 3, 5, 2, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 5, 1, 2, 0, 0, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(nop());
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0000, 1));
        // addu $6 ; addu $7,$0,$6 : B from M
        tbl.push_back(v(0, 0, 1, 1, 6, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 6, 1, 1, 7, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0001, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0000, 1));
        tbl.push_back(nop());
        // register 0 everywhere
        tbl.push_back(v(0, 0, 1, 3, 0, 2, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(nop());
        tbl.push_back(nop());
        // lw $8 ; consumer with Tuse=3 on both : no stall
        tbl.push_back(v(0, 0, 1, 3, 8, 2, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(8, 8, 3, 3, 0, 0, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(nop());
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0000, 1));
        tbl.push_back(nop());
        // addu $10 ; addu $10 ; addu $11,$10,$10 : M wins over W
        tbl.push_back(v(0, 0, 1, 1, 10, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(0, 0, 1, 1, 10, 1, 0, 2'b00, 4'b0000, 0));
        tbl.push_back(v(10, 10, 1, 1, 11, 1, 0, 2'b11, 4'b0000, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0101, 0));
        tbl.push_back(v(0, 0, 3, 3, 0, 0, 0, 2'b00, 4'b0000, 1));
        tbl.push_back(nop());

        // reset state
        rst_n = 1'b0;
        drive(nop());
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(-1, nop());
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_outs(i, tbl[i]);
            @(posedge clk); #1;
        end

        md_seq(1'b1, 100);
        md_seq(1'b0, 200);

        // div in flight, then a load-use stall, then reset mid-cycle
        x = nop(); x.mds = 1'b1; x.mdd = 1'b1; x.mdu = 1'b1;
        drive(x);
        @(posedge clk); #1;
        drive(v(0, 0, 1, 3, 1, 2, 0, 2'b00, 4'b0000, 0));
        @(posedge clk); #1;
        drive(v(1, 1, 1, 1, 2, 1, 0, 2'b00, 4'b0000, 0));
        @(negedge clk);
        chk("pre_rst_stall", 300, 32'(stall), 32'd1);
        chk("pre_rst_busy", 300, 32'(mdBusy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall", 301, 32'(stall), 32'd0);
        chk("rst_busy", 301, 32'(mdBusy), 32'd0);
        chk("rst_dfwd", 301, 32'(dForwardSelect), 32'd0);
        chk("rst_efwd", 301, 32'(eForwardSelect), 32'd0);
        chk("rst_mfwd", 301, 32'(mForwardSelect), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(nop());
        @(negedge clk);
        check_outs(302, nop());
        @(posedge clk); #1;
        @(negedge clk);
        check_outs(303, nop());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
